// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: sequences the PC register and the instruction
// memory port, with a one-entry skid buffer in front of the IF/ID stage.
//
// state | meaning
// IDLE  | no request outstanding; waiting for start_i
// FETCH | request at pc_cur_i outstanding; PC held until ack
// FULL  | output and skid both occupied; waiting for decode to drain
module ifetch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_cur_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              hazard_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              hold_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t            state;
  logic              pend;
  logic [ADDR_W-1:0] pend_target;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_pc;

  logic              accept;
  logic              redirect;
  logic [ADDR_W-1:0] seq_pc;
  state_t            after_state;

  assign accept      = !instr_valid_o || !hazard_i;
  assign redirect    = branch_i || pend;
  assign seq_pc      = pc_cur_i + ADDR_W'(PC_STEP);
  assign imem_addr_o = pc_cur_i;
  assign after_state = start_i ? FETCH : IDLE;

  always_comb begin
    imem_req_o = 1'b0;
    hold_o     = 1'b1;
    next_pc_o  = pc_cur_i;
    case (state)
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          hold_o = 1'b0;
          if (branch_i)  next_pc_o = branch_target_i;
          else if (pend) next_pc_o = pend_target;
          else           next_pc_o = seq_pc;
        end
      end
      FULL: begin
        if (branch_i) begin
          hold_o    = 1'b0;
          next_pc_o = branch_target_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      instr_valid_o <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_pc       <= '0;
      pend          <= 1'b0;
      pend_target   <= '0;
    end else begin
      if (instr_valid_o && !hazard_i)
        instr_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i)
            state <= FETCH;
        end
        FETCH: begin
          if (!imem_ack_i) begin
            // newest redirect wins; the in-flight response will be dropped
            if (branch_i) begin
              pend          <= 1'b1;
              pend_target   <= branch_target_i;
              instr_valid_o <= 1'b0;
            end
          end else begin
            if (redirect) begin
              pend          <= 1'b0;
              instr_valid_o <= 1'b0;
              state         <= after_state;
            end else if (accept) begin
              instr_o       <= imem_data_i;
              instr_pc_o    <= pc_cur_i;
              instr_valid_o <= 1'b1;
              state         <= after_state;
            end else begin
              skid_data  <= imem_data_i;
              skid_pc    <= pc_cur_i;
              skid_valid <= 1'b1;
              state      <= FULL;
            end
          end
        end
        FULL: begin
          if (branch_i) begin
            skid_valid    <= 1'b0;
            instr_valid_o <= 1'b0;
            state         <= after_state;
          end else if (!hazard_i && skid_valid) begin
            instr_o       <= skid_data;
            instr_pc_o    <= skid_pc;
            instr_valid_o <= 1'b1;
            skid_valid    <= 1'b0;
            state         <= after_state;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: local PC register and memory responder, scoreboard of
// fetched {pc,data} pairs compared as decode consumes them.
module tb_ifetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pc_cur_i;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        hazard_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] next_pc_o;
  logic        hold_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;

  ifetch_ctrl #(.ADDR_W(32), .DATA_W(32), .PC_STEP(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_cur_i(pc_cur_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i), .hazard_i(hazard_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i), .next_pc_o(next_pc_o), .hold_o(hold_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_total = 0;
  int          n_bad = 0;
  logic        rst_v = 1'b1;
  logic [31:0] pc_init = '0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] ptgt = '0;
  logic [63:0] q[$];

  // PC register: hazard-hold tied low, hold and load value come from the DUT
  always @(posedge clk_i) begin
    if (rst_i)        pc_cur_i <= pc_init;
    else if (!hold_o) pc_cur_i <= next_pc_o;
  end

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return 32'hAAAA0001 + pc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] tgt, input logic hz);
    logic        consumed;
    logic        full_now;
    logic        exp_hold;
    logic [31:0] exp_next;
    logic [63:0] e;
    @(posedge clk_i);
    #1;
    rst_i = rst_v;
    start_i = st;
    branch_i = br;
    branch_target_i = tgt;
    hazard_i = hz;
    if (!rst_v && imem_req_o) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack_i = 1'b1;
        wait_cnt = 0;
      end else begin
        imem_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack_i = 1'b0;
      wait_cnt = 0;
    end
    imem_data_i = data_of(pc_cur_i);
    #1;
    if (rst_v) begin
      q.delete();
      pend = 1'b0;
      return;
    end
    full_now = !imem_req_o && (q.size() == 2);
    consumed = instr_valid_o && !hz;
    exp_hold = 1'b1;
    exp_next = pc_cur_i;
    if (consumed) begin
      if (q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("sb_instr", {32'd0, instr_o}, {32'd0, e[31:0]});
        chk("sb_pc", {32'd0, instr_pc_o}, {32'd0, e[63:32]});
      end
    end
    if (imem_req_o) begin
      chk("req_addr", {32'd0, imem_addr_o}, {32'd0, pc_cur_i});
      if (imem_ack_i) begin
        exp_hold = 1'b0;
        if (br || pend) begin
          exp_next = br ? tgt : ptgt;
          pend = 1'b0;
          if (instr_valid_o && !consumed && q.size() > 0) q.delete(0);
        end else begin
          exp_next = pc_cur_i + 32'd4;
          q.push_back({pc_cur_i, imem_data_i});
        end
      end else if (br) begin
        pend = 1'b1;
        ptgt = tgt;
        if (instr_valid_o && !consumed && q.size() > 0) q.delete(0);
      end
    end else if (full_now && br) begin
      exp_hold = 1'b0;
      exp_next = tgt;
      q.delete();
    end
    chk("hold", {63'd0, hold_o}, {63'd0, exp_hold});
    chk("next_pc", {32'd0, next_pc_o}, {32'd0, exp_next});
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    pc_init = pc0;
    rst_v = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_v = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset(32'h0);
    chk("rst_req", {63'd0, imem_req_o}, 64'd0);
    chk("rst_hold", {63'd0, hold_o}, 64'd1);
    chk("rst_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("rst_instr", {32'd0, instr_o}, 64'd0);
    chk("rst_ipc", {32'd0, instr_pc_o}, 64'd0);
    chk("rst_next", {32'd0, next_pc_o}, {32'd0, pc_cur_i});

    // zero-wait fetch and back-to-back streaming
    ack_delay = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t1_hold", {63'd0, hold_o}, 64'd0);
    chk("t1_next", {32'd0, next_pc_o}, 64'h4);
    step(1, 0, 0, 0);
    chk("t1_instr", {32'd0, instr_o}, 64'hAAAA0001);
    chk("t1_ipc", {32'd0, instr_pc_o}, 64'h0);
    chk("t1_valid", {63'd0, instr_valid_o}, 64'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // delayed ack holds the PC
    do_reset(32'h100);
    ack_delay = 3;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("t2_wait_hold", {63'd0, hold_o}, 64'd1);
      chk("t2_wait_addr", {32'd0, imem_addr_o}, 64'h100);
    end
    step(0, 0, 0, 0);
    chk("t2_ack_hold", {63'd0, hold_o}, 64'd0);
    chk("t2_ack_next", {32'd0, next_pc_o}, 64'h104);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);

    // branch during wait: response dropped, refetch at target
    do_reset(32'h180);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 32'h200, 0);
    chk("t3_br_hold", {63'd0, hold_o}, 64'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t3_ack_hold", {63'd0, hold_o}, 64'd0);
    chk("t3_ack_next", {32'd0, next_pc_o}, 64'h200);
    step(0, 0, 0, 0);
    chk("t3_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("t3_req", {63'd0, imem_req_o}, 64'd1);
    chk("t3_addr", {32'd0, imem_addr_o}, 64'h200);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    // hazard fills the skid, drain resumes fetching
    do_reset(32'h300);
    ack_delay = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("t4_full_req", {63'd0, imem_req_o}, 64'd0);
    chk("t4_full_valid", {63'd0, instr_valid_o}, 64'd1);
    chk("t4_full_ipc", {32'd0, instr_pc_o}, 64'h300);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t4_skid_instr", {32'd0, instr_o}, {32'd0, data_of(32'h304)});
    chk("t4_skid_ipc", {32'd0, instr_pc_o}, 64'h304);
    chk("t4_resume_req", {63'd0, imem_req_o}, 64'd1);
    chk("t4_resume_addr", {32'd0, imem_addr_o}, 64'h308);

    // branch while FULL flushes output and skid
    step(1, 0, 0, 1);
    step(1, 1, 32'h40, 1);
    chk("t5_hold", {63'd0, hold_o}, 64'd0);
    chk("t5_next", {32'd0, next_pc_o}, 64'h40);
    step(1, 0, 0, 0);
    chk("t5_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("t5_addr", {32'd0, imem_addr_o}, 64'h40);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("sb_empty", q.size(), 64'd0);

    // PC wrap, then reset mid-wait
    do_reset(32'hFFFFFFFC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_wrap_next", {32'd0, next_pc_o}, 64'h0);
    ack_delay = 5;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    rst_v = 1'b1;
    step(1, 0, 0, 0);
    rst_v = 1'b0;
    step(0, 0, 0, 0);
    chk("t6_rst_req", {63'd0, imem_req_o}, 64'd0);
    chk("t6_rst_valid", {63'd0, instr_valid_o}, 64'd0);
    step(0, 0, 0, 0);
    chk("t6_idle_req", {63'd0, imem_req_o}, 64'd0);
    chk("sb_empty_end", q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
